// File: rtl/frame_arb_pkg.sv
// Shared definitions for the SDRAM frame arbiter and the camera/VGA address logic.
package frame_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  // 640x480 frame of 16-bit words, moved in 8-word bursts.
  localparam int unsigned FRAME_WORDS_DFLT = 307200;
  localparam int unsigned BURST_LEN_DFLT   = 8;

endpackage

// File: rtl/frame_offset_ctr.sv
// Per-channel burst offset within a frame buffer, with a frame-start request
// that is held pending until the arbiter reaches a point where it may be applied.
module frame_offset_ctr
  import frame_arb_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DFLT,
  parameter int unsigned BURST_LEN   = BURST_LEN_DFLT,
  parameter int unsigned OFF_W       = $clog2(FRAME_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,         // burst for this channel completed
  input  logic             frame_start,  // frame-start pulse for this channel
  input  logic             apply,        // arbiter may apply frame starts this cycle
  output logic [OFF_W-1:0] off_nxt,      // offset after this cycle's step/clear
  output logic             at_end,       // offset (after step) reached end of frame
  output logic             clear         // frame start takes effect this cycle
);

  logic [OFF_W-1:0] off_q, off_d, off_adv;
  logic             pend_q, pend_d;

  // Step first, then let an applied frame start override back to zero.
  always_comb begin
    off_adv = step ? (off_q + OFF_W'(BURST_LEN)) : off_q;
    clear   = apply & (pend_q | frame_start);
    at_end  = (off_adv == OFF_W'(FRAME_WORDS));
    off_d   = clear ? '0 : off_adv;
    pend_d  = apply ? 1'b0 : (pend_q | frame_start);
    off_nxt = off_d;
  end

  // Offset and pending-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      off_q  <= off_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the SDRAM command port between camera writes and VGA reads and
// steers them into ping-pong frame buffers so display shows the last full frame.
module sdram_frame_arbiter
  import frame_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN     = BURST_LEN_DFLT,
  parameter int unsigned FRAME_WORDS   = FRAME_WORDS_DFLT,
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned LVL_W         = 10,
  parameter int unsigned RD_FIFO_DEPTH = 512,
  parameter int unsigned RD_LOW_WM     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LVL_W-1:0]  wr_lvl,
  input  logic              wr_frame_start,
  input  logic [LVL_W-1:0]  rd_lvl,
  input  logic              rd_frame_start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_done,
  output logic              wbuf,
  output logic              rbuf,
  output logic              frame_ready
);

  localparam int unsigned      OFF_W      = $clog2(FRAME_WORDS + 1);
  localparam logic [LVL_W-1:0] LVL_BURST  = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] LVL_RD_MAX = LVL_W'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [LVL_W-1:0] LVL_LOW    = LVL_W'(RD_LOW_WM);

  function automatic logic [ADDR_W-1:0] burst_addr(input logic b, input logic [OFF_W-1:0] off);
    return (b ? ADDR_W'(FRAME_WORDS) : '0) + ADDR_W'(off);
  endfunction

  arb_state_e        state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wbuf_q, wbuf_d, rbuf_q, rbuf_d, rbuf_next_q, rbuf_next_d;
  logic              frame_ready_q, frame_ready_d, last_wr_q, last_wr_d;

  logic             done_evt, apply, wstep, rstep;
  logic [OFF_W-1:0] woff_nxt, roff_nxt;
  logic             wend, rend, wclr, rclr, swap;
  logic             wr_elig, rd_elig, rd_urgent, grant_wr;

  // Frame starts land in IDLE immediately, otherwise on the burst-completion cycle.
  assign done_evt = (state_q == ST_BUSY) & cmd_done;
  assign apply    = (state_q == ST_IDLE) | done_evt;
  assign wstep    = done_evt & cmd_write_q;
  assign rstep    = done_evt & ~cmd_write_q;

  frame_offset_ctr #(.FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .OFF_W(OFF_W)) u_woff (
    .clk(clk), .rst_n(rst_n), .step(wstep), .frame_start(wr_frame_start),
    .apply(apply), .off_nxt(woff_nxt), .at_end(wend), .clear(wclr)
  );

  frame_offset_ctr #(.FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .OFF_W(OFF_W)) u_roff (
    .clk(clk), .rst_n(rst_n), .step(rstep), .frame_start(rd_frame_start),
    .apply(apply), .off_nxt(roff_nxt), .at_end(rend), .clear(rclr)
  );

  // Buffer bookkeeping: a complete frame swaps buffers, and a read frame start
  // in the same cycle already sees the freshly completed buffer.
  always_comb begin
    swap          = wclr & wend;
    wbuf_d        = swap ? ~wbuf_q : wbuf_q;
    rbuf_next_d   = swap ? wbuf_q : rbuf_next_q;
    frame_ready_d = frame_ready_q | swap;
    rbuf_d        = rclr ? rbuf_next_d : rbuf_q;
  end

  // Eligibility is only consumed in IDLE, where no step is in progress, so a
  // channel is open when its offset is short of the end or is being cleared.
  assign wr_elig   = (wr_lvl >= LVL_BURST) & (wclr | ~wend);
  assign rd_elig   = frame_ready_d & (rclr | ~rend) & (rd_lvl <= LVL_RD_MAX);
  assign rd_urgent = rd_elig & (rd_lvl < LVL_LOW);
  assign grant_wr  = rd_urgent ? 1'b0 : ((wr_elig & rd_elig) ? ~last_wr_q : wr_elig);

  // Command FSM: grant in IDLE, offer in ISSUE, wait for completion in BUSY.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    last_wr_d   = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_elig | rd_elig) begin
          cmd_valid_d = 1'b1;
          cmd_write_d = grant_wr;
          cmd_addr_d  = grant_wr ? burst_addr(wbuf_d, woff_nxt) : burst_addr(rbuf_d, roff_nxt);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cmd_done) begin
          last_wr_d = cmd_write_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, command and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      wbuf_q        <= 1'b0;
      rbuf_q        <= 1'b0;
      rbuf_next_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      last_wr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_addr_q    <= cmd_addr_d;
      wbuf_q        <= wbuf_d;
      rbuf_q        <= rbuf_d;
      rbuf_next_q   <= rbuf_next_d;
      frame_ready_q <= frame_ready_d;
      last_wr_q     <= last_wr_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign wbuf        = wbuf_q;
  assign rbuf        = rbuf_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Randomized bench for sdram_frame_arbiter with a transaction-level reference model.
module tb_sdram_frame_arbiter;

  localparam int BL    = 8;
  localparam int FW    = 256;
  localparam int AW    = 24;
  localparam int LW    = 10;
  localparam int DEPTH = 512;
  localparam int LOWWM = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] wr_lvl, rd_lvl;
  logic          wr_frame_start, rd_frame_start, cmd_ready, cmd_done;
  logic          cmd_valid, cmd_write, wbuf, rbuf, frame_ready;
  logic [AW-1:0] cmd_addr;

  always #5 clk = ~clk;

  sdram_frame_arbiter #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .LVL_W(LW),
    .RD_FIFO_DEPTH(DEPTH), .RD_LOW_WM(LOWWM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_lvl(wr_lvl), .wr_frame_start(wr_frame_start),
    .rd_lvl(rd_lvl), .rd_frame_start(rd_frame_start), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_done(cmd_done), .wbuf(wbuf), .rbuf(rbuf), .frame_ready(frame_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model of the frame/burst bookkeeping.
  int m_woff, m_roff;
  bit m_wbuf, m_rbuf, m_rnext, m_ready, m_last_wr, m_wpend, m_rpend;

  task automatic m_reset();
    m_woff = 0; m_roff = 0; m_wbuf = 0; m_rbuf = 0; m_rnext = 0;
    m_ready = 0; m_last_wr = 0; m_wpend = 0; m_rpend = 0;
  endtask

  task automatic m_apply(input bit w, input bit r);
    if (w) begin
      if (m_woff == FW) begin
        m_rnext = m_wbuf;
        m_wbuf  = !m_wbuf;
        m_ready = 1;
      end
      m_woff = 0;
    end
    if (r) begin
      m_rbuf = m_rnext;
      m_roff = 0;
    end
  endtask

  task automatic m_pick(output bit any, output bit w, output int addr);
    bit we, re, urg;
    we  = (int'(wr_lvl) >= BL) && (m_woff < FW);
    re  = m_ready && (m_roff < FW) && (int'(rd_lvl) <= DEPTH - BL);
    urg = re && (int'(rd_lvl) < LOWWM);
    any = we || re;
    if (urg)           w = 0;
    else if (we && re) w = !m_last_wr;
    else               w = we;
    addr = w ? (int'(m_wbuf) * FW + m_woff) : (int'(m_rbuf) * FW + m_roff);
  endtask

  task automatic chk_bufs(input string tag);
    chk({tag, "_wbuf"}, wbuf, m_wbuf);
    chk({tag, "_rbuf"}, rbuf, m_rbuf);
    chk({tag, "_frame_ready"}, frame_ready, m_ready);
  endtask

  function automatic logic [LW-1:0] rand_wl();
    return ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 7)) : LW'($urandom_range(8, 1023));
  endfunction

  function automatic logic [LW-1:0] rand_rl();
    case ($urandom_range(0, 2))
      0:       return LW'($urandom_range(0, 127));
      1:       return LW'($urandom_range(128, 504));
      default: return LW'($urandom_range(505, 1023));
    endcase
  endfunction

  // One full command: offer, optional stall, accept, busy window, completion.
  task automatic run_cmd(input int hold, input int lat, input bit wfs, input bit rfs,
                         input bit chg, input logic [LW-1:0] nwl, input logic [LW-1:0] nrl);
    bit any, ew;
    int ea, n;
    m_pick(any, ew, ea);
    n = 0;
    while (!cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) begin
      chk("cmd_timeout", 0, 1);
      return;
    end
    chk("cmd_write", cmd_write, ew);
    chk("cmd_addr", cmd_addr, ea);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", cmd_valid, 1);
      chk("hold_write", cmd_write, ew);
      chk("hold_addr", cmd_addr, ea);
    end
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    chk("valid_drop", cmd_valid, 0);
    wr_frame_start = wfs;
    rd_frame_start = rfs;
    m_wpend = m_wpend | wfs;
    m_rpend = m_rpend | rfs;
    if (chg) begin
      wr_lvl = nwl;
      rd_lvl = nrl;
    end
    repeat (lat) begin
      @(negedge clk);
      wr_frame_start = 0;
      rd_frame_start = 0;
    end
    cmd_done = 1;
    @(negedge clk);
    cmd_done = 0;
    wr_frame_start = 0;
    rd_frame_start = 0;
    if (ew) m_woff += BL;
    else    m_roff += BL;
    m_last_wr = ew;
    m_apply(m_wpend, m_rpend);
    m_wpend = 0;
    m_rpend = 0;
    chk_bufs("done");
  endtask

  // Change levels and pulse frame starts while the arbiter is in IDLE.
  task automatic idle_kick(input logic [LW-1:0] wl, input logic [LW-1:0] rl, input bit w, input bit r);
    wr_lvl = wl;
    rd_lvl = rl;
    wr_frame_start = w;
    rd_frame_start = r;
    m_apply(w, r);
    @(negedge clk);
    wr_frame_start = 0;
    rd_frame_start = 0;
    chk_bufs("kick");
  endtask

  // Nothing eligible: no command may appear, stray handshakes are ignored.
  task automatic expect_idle(input int n);
    cmd_done  = 1;
    cmd_ready = 1;
    repeat (n) begin
      @(negedge clk);
      cmd_done  = 0;
      cmd_ready = 0;
      chk("no_cmd", cmd_valid, 0);
    end
  endtask

  initial begin
    bit any, ew, fresh;
    int ea, iter;
    rst_n = 0; wr_lvl = 8; rd_lvl = 0;
    wr_frame_start = 0; rd_frame_start = 0; cmd_ready = 0; cmd_done = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_write", cmd_write, 0);
    chk("rst_addr", cmd_addr, 0);
    chk_bufs("rst");
    rst_n = 1;

    // First frame: writes only, addresses 0, 8, 16, ...
    for (int i = 0; i < FW / BL; i++)
      run_cmd($urandom_range(0, 3), $urandom_range(0, 4), 0, 0, 0, 8, 0);
    expect_idle(4);

    // Completed frame swaps buffers; writes restart at the other base.
    idle_kick(8, 600, 1, 0);
    run_cmd(0, 1, 0, 0, 0, 8, 0);
    // Display frame start: both eligible, grants alternate, then urgent read wins.
    idle_kick(8, 300, 0, 1);
    run_cmd(0, 1, 0, 0, 0, 8, 0);
    run_cmd(0, 1, 0, 0, 0, 8, 0);
    run_cmd(0, 1, 0, 0, 1, 8, 100);
    run_cmd(0, 1, 0, 0, 0, 8, 0);
    run_cmd(10, 2, 0, 1, 1, 8, 300);
    run_cmd(0, 1, 1, 0, 0, 8, 0);
    run_cmd(0, 0, 0, 0, 0, 8, 0);

    // Randomized traffic.
    fresh = 1;
    iter  = 0;
    while (iter < 400 || !fresh) begin
      iter++;
      m_pick(any, ew, ea);
      if (!any) begin
        expect_idle(2);
        idle_kick(rand_wl(), rand_rl(), (m_woff == FW) && ($urandom_range(0, 1) == 1),
                  (m_roff == FW) && ($urandom_range(0, 1) == 1));
        m_pick(any, ew, ea);
        fresh = !any;
      end else if (fresh && $urandom_range(0, 9) == 0) begin
        idle_kick(rand_wl(), rand_rl(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        m_pick(any, ew, ea);
        fresh = !any;
      end else begin
        run_cmd($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, rand_wl(), rand_rl());
        fresh = 1;
      end
    end

    // Asynchronous reset while a command is being offered.
    idle_kick(50, 600, m_woff == FW, 0);
    chk("pre_rst_valid", cmd_valid, 1);
    #2 rst_n = 0;
    #1 chk("async_rst_valid", cmd_valid, 0);
    m_reset();
    chk("async_rst_write", cmd_write, 0);
    chk("async_rst_addr", cmd_addr, 0);
    chk_bufs("async_rst");
    @(negedge clk);
    rst_n = 1;
    rd_lvl = 300;
    run_cmd(1, 1, 0, 0, 0, 50, 300);
    run_cmd(0, 1, 0, 0, 0, 50, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
